// File: rtl/vga_fb_sched_pkg.sv
// Shared constants, prefetch FSM states and colour expansion for the
// 160x120 RGB444 frame-buffer scheduler.
package vga_fb_sched_pkg;

    localparam int unsigned FB_W     = 160;
    localparam int unsigned FB_H     = 120;
    localparam int unsigned FB_DEPTH = FB_W * FB_H;

    typedef enum logic [1:0] {
        WAIT_HS = 2'd0,
        PF_REQ  = 2'd1,
        PF_DONE = 2'd2
    } pf_state_t;

    // RGB444 -> RGB888 by duplicating each nibble
    function automatic logic [23:0] rgb444_to_888(input logic [11:0] p);
        return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
    endfunction

endpackage

// File: rtl/vga_fb_addr.sv
// Row/column to frame-buffer word address: row*160 + col.
module vga_fb_addr (
    input  logic [7:0]  i_row,
    input  logic [7:0]  i_col,
    output logic [14:0] o_word
);

    // row*160 built as row*128 + row*32 to avoid a multiplier
    always_comb begin
        o_word = {i_row, 7'b0} + {2'b0, i_row, 5'b0} + {7'b0, i_col};
    end

endmodule

// File: rtl/vga_fb_sched.sv
// Time-slices a single-port frame-buffer RAM between display fetch and one
// writer. Display reads always win; each fetched word is shown as a 4x4 block.
module vga_fb_sched #(
    parameter int unsigned FB_W = 160,
    parameter int unsigned FB_H = 120,
    parameter int unsigned AW   = 15
) (
    input  logic          i_pclk,
    input  logic          i_reset,
    input  logic [9:0]    i_h_addr,
    input  logic [9:0]    i_v_addr,
    input  logic          i_valid,
    input  logic          i_hsync,
    input  logic          i_wr_req,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [11:0]   i_wr_data,
    output logic          o_wr_ack,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [11:0]   o_mem_wdata,
    input  logic [11:0]   i_mem_rdata,
    output logic [23:0]   o_vga_data
);
    import vga_fb_sched_pkg::pf_state_t, vga_fb_sched_pkg::WAIT_HS,
           vga_fb_sched_pkg::PF_REQ, vga_fb_sched_pkg::PF_DONE,
           vga_fb_sched_pkg::rgb444_to_888;

    localparam logic [AW-1:0] DEPTH = AW'(FB_W * FB_H);

    pf_state_t   state_q, state_d;
    logic        hs_q, hs_rise_q, val_q, rd_pend_q;
    logic [11:0] cur_pix_q, nxt_pix_q;
    logic        pf_rd, line_rd, dslot, cur_load;
    logic [7:0]  col, row, addr_col;
    logic [14:0] disp_word;

    assign col = i_h_addr[9:2];
    assign row = i_v_addr[9:2];

    // Active-line reads are limited to PF_DONE so that a reset mid-line keeps
    // the picture black until the next line's prefetch re-seeds the pipeline.
    assign pf_rd    = (state_q == PF_REQ);
    assign line_rd  = (state_q == PF_DONE) & i_valid & (i_h_addr[1:0] == 2'b01) &
                      (col < 8'(FB_W - 1));
    assign dslot    = ~i_reset & (pf_rd | line_rd);
    assign addr_col = pf_rd ? 8'd0 : col + 8'd1;
    assign cur_load = ~i_valid | (i_h_addr[1:0] == 2'b11);

    vga_fb_addr u_addr (
        .i_row  (row),
        .i_col  (addr_col),
        .o_word (disp_word)
    );

    // Prefetch FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_HS: if (hs_rise_q && !i_valid) state_d = PF_REQ;
            PF_REQ:  state_d = PF_DONE;
            PF_DONE: if (val_q && !i_valid) state_d = WAIT_HS;
            default: state_d = WAIT_HS;
        endcase
    end

    // State, edge detectors, read tracking and the two-stage pixel pipeline
    always_ff @(posedge i_pclk) begin
        if (i_reset) begin
            state_q   <= WAIT_HS;
            hs_q      <= 1'b1;
            hs_rise_q <= 1'b0;
            val_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            nxt_pix_q <= '0;
            cur_pix_q <= '0;
        end else begin
            state_q   <= state_d;
            hs_q      <= i_hsync;
            hs_rise_q <= i_hsync & ~hs_q;
            val_q     <= i_valid;
            rd_pend_q <= dslot;
            if (rd_pend_q) nxt_pix_q <= i_mem_rdata;
            if (cur_load)  cur_pix_q <= nxt_pix_q;
        end
    end

    // RAM port arbitration: display slot first, then the writer
    always_comb begin
        o_wr_ack    = i_wr_req & ~dslot & ~i_reset;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (dslot) begin
            o_mem_en   = 1'b1;
            o_mem_addr = AW'(disp_word);
        end else if (o_wr_ack) begin
            o_mem_en    = 1'b1;
            o_mem_we    = (i_wr_addr < DEPTH);
            o_mem_addr  = i_wr_addr;
            o_mem_wdata = i_wr_data;
        end
    end

    // Colour output, black outside active video and during reset
    always_comb begin
        o_vga_data = (i_valid & ~i_reset) ? rgb444_to_888(cur_pix_q) : '0;
    end

endmodule

// File: tb/tb_vga_fb_sched.sv
// Randomized bench for vga_fb_sched with a line-buffer level reference model
// and a behavioural single-port RAM.
module tb_vga_fb_sched;

    localparam int DEPTH = 19200;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h, v;
    logic        valid, hsync, wr_req;
    logic [14:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack, mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata = '0;
    logic [23:0] vga;

    always #5 clk = ~clk;

    vga_fb_sched #(.FB_W(160), .FB_H(120), .AW(15)) dut (
        .i_pclk      (clk),
        .i_reset     (rst),
        .i_h_addr    (h),
        .i_v_addr    (v),
        .i_valid     (valid),
        .i_hsync     (hsync),
        .i_wr_req    (wr_req),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .o_wr_ack    (wr_ack),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .o_vga_data  (vga)
    );

    // Behavioural single-port RAM, one-cycle read latency
    logic [11:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_en && int'(mem_addr) < DEPTH) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Reference model state
    logic [11:0] shadow   [0:DEPTH-1];
    logic [11:0] line_buf [0:159];
    bit  armed, in_pf_done, disp_ok, hs_prev, val_prev;
    int  rise_age;
    int  wr_mode;
    int  dir_mode;
    int  line_acks;
    bit  obs_ack, obs_we;
    logic [14:0] obs_addr;
    int unsigned nvec = 0, nerr = 0;

    function automatic logic [23:0] expand(input logic [11:0] p);
        return {p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic new_req();
        wr_req = 1'b1;
        if ($urandom_range(0, 15) == 0) wr_addr = 15'($urandom_range(DEPTH, 32767));
        else                            wr_addr = 15'($urandom_range(0, DEPTH - 1));
        wr_data = 12'($urandom);
    endtask

    // One pixel clock: predict, compare at negedge, advance model, move writer
    task automatic step();
        int col, row;
        bit pf_now, line_rd, dslot, ack_e, we_e;
        logic [14:0] daddr;
        logic [23:0] vga_e;
        col = int'(h[9:2]);
        row = int'(v[9:2]);
        if (rst)                     rise_age = 99;
        else if (hsync && !hs_prev)  rise_age = 0;
        else if (rise_age < 99)      rise_age++;
        pf_now  = !rst && armed && rise_age == 2;
        line_rd = !rst && in_pf_done && valid && h[1:0] == 2'b01 && col < 159;
        dslot   = pf_now || line_rd;
        daddr   = pf_now ? 15'(row * 160) : 15'(row * 160 + col + 1);
        ack_e   = wr_req && !rst && !dslot;
        we_e    = ack_e && int'(wr_addr) < DEPTH;
        vga_e   = (valid && !rst && disp_ok) ? expand(line_buf[col]) : 24'h0;

        @(negedge clk);
        obs_ack  = wr_ack;
        obs_we   = mem_we;
        obs_addr = mem_addr;
        chk("wr_ack", wr_ack, ack_e);
        chk("mem_en", mem_en, dslot || ack_e);
        if (dslot) begin
            chk("rd_addr", mem_addr, daddr);
            chk("rd_we", mem_we, 1'b0);
        end
        if (ack_e) begin
            chk("wr_addr", mem_addr, wr_addr);
            chk("wr_we", mem_we, we_e);
            if (we_e) chk("wr_data", mem_wdata, wr_data);
        end
        chk("vga", vga, vga_e);
        if (dir_mode == 1 && valid && h < 8)
            chk("px_word01", vga, (h < 4) ? 24'hFF0000 : 24'h00FF00);
        if (dir_mode == 2 && valid && h == 639)
            chk("px_639_479", vga, 24'h0000FF);
        if (valid && wr_ack) line_acks++;

        if (rst) begin
            armed = 1; in_pf_done = 0; disp_ok = 0; hs_prev = 1; val_prev = 0;
        end else begin
            if (dslot) line_buf[pf_now ? 0 : col + 1] = shadow[daddr];
            if (pf_now) begin armed = 0; in_pf_done = 1; disp_ok = 1; end
            if (val_prev && !valid) begin in_pf_done = 0; armed = 1; end
            hs_prev  = hsync;
            val_prev = valid;
            if (we_e) shadow[wr_addr] = wr_data;
        end

        @(posedge clk);
        #1;
        if (ack_e) wr_req = 1'b0;
        if (!wr_req) begin
            if (wr_mode == 1 && $urandom_range(0, 3) == 0) new_req();
            else if (wr_mode == 2) new_req();
        end
    endtask

    // One video line: front porch, sync pulse, back porch, 640 active pixels
    task automatic run_line(input int y, input int rst_x, input bit pf_wr, input bit chk_acks);
        valid = 0; h = '0; v = 10'(y); hsync = 1;
        repeat (4) step();
        hsync = 0;
        repeat (8) step();
        hsync = 1;
        for (int i = 0; i < 30; i++) begin
            if (pf_wr && i == 2) begin wr_req = 1; wr_addr = 15'd500; wr_data = 12'hABC; end
            step();
            if (pf_wr && i == 2) begin
                chk("pf_ack_held", obs_ack, 1'b0);
                chk("pf_addr", obs_addr, 15'((y / 4) * 160));
            end
            if (pf_wr && i == 3) chk("pf_retry_ack", obs_ack, 1'b1);
        end
        line_acks = 0;
        for (int x = 0; x < 640; x++) begin
            valid = 1; h = 10'(x); v = 10'(y); rst = (x == rst_x);
            step();
        end
        rst = 0; valid = 0; h = '0;
        if (chk_acks) chk("acks_per_line", line_acks, 481);
    endtask

    task automatic wr_one(input int a, input logic [11:0] d, input bit exp_we);
        bit done;
        done = 0;
        valid = 0; h = '0; hsync = 1;
        wr_req = 1; wr_addr = 15'(a); wr_data = d;
        for (int i = 0; i < 8 && !done; i++) begin
            step();
            if (obs_ack) begin
                done = 1;
                chk("oob_or_edge_we", obs_we, exp_we);
            end
        end
        if (!done) chk("wr_ack_timeout", obs_ack, 1'b1);
        wr_req = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]    = 12'($urandom);
            shadow[i] = ram[i];
        end
        ram[0] = 12'hF00; shadow[0] = 12'hF00;
        ram[1] = 12'h0F0; shadow[1] = 12'h0F0;
        armed = 1; in_pf_done = 0; disp_ok = 0; hs_prev = 1; val_prev = 0;
        rise_age = 99; wr_mode = 0; dir_mode = 0; line_acks = 0;

        rst = 1; valid = 1; h = 10'd5; v = '0; hsync = 1;
        wr_req = 1; wr_addr = 15'd5; wr_data = 12'h123;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_ack", obs_ack, 1'b0);
        end
        rst = 0; wr_req = 0; valid = 0; h = '0;

        dir_mode = 1;
        run_line(0, -1, 0, 0);
        dir_mode = 0;

        wr_mode = 1;
        for (int n = 0; n < 6; n++) run_line(int'($urandom_range(0, 479)), -1, 0, 0);

        wr_mode = 2;
        for (int n = 0; n < 2; n++) run_line(int'($urandom_range(0, 479)), -1, 0, 1);

        wr_mode = 0;
        wr_req = 0;
        run_line(int'($urandom_range(0, 479)), -1, 1, 0);

        wr_one(19200, 12'h123, 1'b0);
        wr_one(19199, 12'h00F, 1'b1);
        dir_mode = 2;
        run_line(479, -1, 0, 0);
        dir_mode = 0;

        wr_mode = 1;
        run_line(int'($urandom_range(0, 479)), 300, 0, 0);
        for (int n = 0; n < 3; n++) run_line(int'($urandom_range(0, 479)), -1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
